// File: rtl/matmul_sequencer.sv
// Bus master computing C = A x B for an N x N word matrix held in the data memory.
// Define MATMUL_SAT_EN to saturate each C element to signed 32 bits instead of wrapping.
module matmul_sequencer #(
    parameter int          N      = 3,
    parameter logic [31:0] A_BASE = 32'h0000_0200,
    parameter logic [31:0] B_BASE = 32'h0000_0300,
    parameter logic [31:0] C_BASE = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] address,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [63:0] acc_q, acc_d;
    logic signed [31:0] a_q, a_d;

    logic signed [63:0] a_ext, r_ext, prod;
    logic [31:0]        result;
    logic [31:0]        idx_a, idx_b, idx_c;

    // Full 64-bit signed product; the low 64 bits of a 64x64 multiply are exact here.
    assign a_ext = {{32{a_q[31]}}, a_q};
    assign r_ext = {{32{rdata[31]}}, rdata};
    assign prod  = a_ext * r_ext;

`ifdef MATMUL_SAT_EN
    localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;
    always_comb begin
        if (acc_q > SAT_MAX)      result = 32'h7FFF_FFFF;
        else if (acc_q < SAT_MIN) result = 32'h8000_0000;
        else                      result = acc_q[31:0];
    end
`else
    assign result = acc_q[31:0];
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_A;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_RD_A: begin
                a_d     = rdata;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                acc_d = acc_q + prod;
                if (k_q == LAST) begin
                    state_d = S_WR;
                end else begin
                    k_d     = k_q + CW'(1);
                    state_d = S_RD_A;
                end
            end
            S_WR: begin
                acc_d = '0;
                k_d   = '0;
                if (j_q == LAST) begin
                    j_d = '0;
                    i_d = (i_q == LAST) ? '0 : i_q + CW'(1);
                end else begin
                    j_d = j_q + CW'(1);
                end
                state_d = (i_q == LAST && j_q == LAST) ? S_DONE : S_RD_A;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
        end
    end

    // Word indices into the row-major matrices; bus outputs depend only on registers.
    assign idx_a = 32'(i_q) * 32'(N) + 32'(k_q);
    assign idx_b = 32'(k_q) * 32'(N) + 32'(j_q);
    assign idx_c = 32'(i_q) * 32'(N) + 32'(j_q);

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        memread  = 1'b0;
        memwrite = 1'b0;
        address  = '0;
        wdata    = '0;
        case (state_q)
            S_RD_A: begin
                memread = 1'b1;
                address = A_BASE + (idx_a << 2);
            end
            S_RD_B: begin
                memread = 1'b1;
                address = B_BASE + (idx_b << 2);
            end
            S_WR: begin
                memwrite = 1'b1;
                address  = C_BASE + (idx_c << 2);
                wdata    = result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a behavioural word memory on the bus.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, memread, memwrite;
    logic [31:0] address, wdata, rdata;

    matmul_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .memread  (memread),
        .memwrite (memwrite),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_BASE = 32'h0000_0200;
    localparam logic [31:0] B_BASE = 32'h0000_0300;
    localparam logic [31:0] C_BASE = 32'h0000_0100;

    logic [31:0] mem [0:255];
    always_comb rdata = mem[address[9:2]];

    // Bus monitor: logs writes, every bus access, done pulses and strobe overlap.
    int          wr_cnt = 0, bus_cnt = 0, done_cnt = 0, both_cnt = 0;
    logic [31:0] wr_addr [0:127];
    logic [31:0] wr_data [0:127];
    logic [31:0] bus_addr [0:1023];
    logic [1:0]  bus_kind [0:1023];

    always @(negedge clk) begin
        if (memwrite && wr_cnt < 128) begin
            wr_addr[wr_cnt] <= address;
            wr_data[wr_cnt] <= wdata;
            wr_cnt          <= wr_cnt + 1;
        end
        if ((memread || memwrite) && bus_cnt < 1024) begin
            bus_addr[bus_cnt] <= address;
            bus_kind[bus_cnt] <= {memread, memwrite};
            bus_cnt           <= bus_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (memread && memwrite) both_cnt <= both_cnt + 1;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [4];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_uniform(input logic [31:0] a, input logic [31:0] b);
        for (int e = 0; e < 9; e++) begin
            mem[(A_BASE >> 2) + e] = a;
            mem[(B_BASE >> 2) + e] = b;
        end
    endtask

    task automatic load_identity();
        for (int e = 0; e < 9; e++) begin
            mem[(A_BASE >> 2) + e] = (e % 4 == 0) ? 32'd1 : 32'd0;
            mem[(B_BASE >> 2) + e] = 32'(e + 1);
        end
    endtask

    // Pulses start, then counts cycles after the accept edge until done is seen.
    task automatic run(input int restart_at, output int done_at);
        done_at = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (done) begin
                done_at = n;
                break;
            end
            start = (n == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int base, input logic [31:0] exp_u, input bit ident);
        logic [31:0] exp;
        for (int e = 0; e < 9; e++) begin
            exp = ident ? 32'(e + 1) : exp_u;
            check($sformatf("%s_addr%0d", tag, e), wr_addr[base + e], C_BASE + 32'(4 * e));
            check($sformatf("%s_data%0d", tag, e), wr_data[base + e], exp);
            $display("%s write %0d: addr=%h data=%h", tag, e, wr_addr[base + e], wr_data[base + e]);
        end
    endtask

    task automatic finish_run(input string tag, input int base, input int dbase, input int done_at);
        check({tag, "_done_at"}, 64'(done_at), 64'd64);
        @(negedge clk);
        check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        check({tag, "_done_width"}, {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        check({tag, "_wr_count"}, 64'(wr_cnt - base), 64'd9);
        check({tag, "_done_count"}, 64'(done_cnt - dbase), 64'd1);
    endtask

    initial begin
        int done_at, base, dbase, bbase, idx, ii, jj;

        vecs[0] = '{a: 32'd1024,       b: 32'd256,   exp: 32'd786432};
`ifdef MATMUL_SAT_EN
        vecs[1] = '{a: 32'd65536,      b: 32'd65536, exp: 32'h7FFF_FFFF};
`else
        vecs[1] = '{a: 32'd65536,      b: 32'd65536, exp: 32'h0000_0000};
`endif
        vecs[2] = '{a: 32'hFFFF_FFFE,  b: 32'd3,     exp: 32'hFFFF_FFEE};
        vecs[3] = '{a: 32'd7,          b: 32'hFFFF_FFFB, exp: 32'hFFFF_FF97};

        for (int e = 0; e < 256; e++) mem[e] = 32'd0;

        // Reset values
        #12;
        check("rst_strobes", {60'd0, busy, done, memread, memwrite}, 64'd0);
        check("rst_addr", {32'd0, address}, 64'd0);
        check("rst_wdata", {32'd0, wdata}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("idle_strobes", {60'd0, busy, done, memread, memwrite}, 64'd0);

        // Uniform matrices from the table
        for (int v = 0; v < 4; v++) begin
            load_uniform(vecs[v].a, vecs[v].b);
            base  = wr_cnt;
            dbase = done_cnt;
            run(0, done_at);
            finish_run($sformatf("vec%0d", v), base, dbase, done_at);
            check_writes($sformatf("vec%0d", v), base, vecs[v].exp, 1'b0);
        end

        // Identity x 1..9, with full bus access order
        load_identity();
        base  = wr_cnt;
        dbase = done_cnt;
        bbase = bus_cnt;
        run(0, done_at);
        finish_run("ident", base, dbase, done_at);
        check_writes("ident", base, 32'd0, 1'b1);
        for (int e = 0; e < 9; e++) begin
            ii = e / 3;
            jj = e % 3;
            for (int k = 0; k < 3; k++) begin
                idx = bbase + e * 7 + 2 * k;
                check($sformatf("seq_e%0d_k%0d_a", e, k), {30'd0, bus_kind[idx], bus_addr[idx]},
                      {30'd0, 2'b10, A_BASE + 32'(4 * (3 * ii + k))});
                check($sformatf("seq_e%0d_k%0d_b", e, k), {30'd0, bus_kind[idx + 1], bus_addr[idx + 1]},
                      {30'd0, 2'b10, B_BASE + 32'(4 * (3 * k + jj))});
            end
            idx = bbase + e * 7 + 6;
            check($sformatf("seq_e%0d_wr", e), {30'd0, bus_kind[idx], bus_addr[idx]},
                  {30'd0, 2'b01, C_BASE + 32'(4 * e)});
        end

        // Start pulsed again mid-run must be ignored
        load_uniform(32'd1024, 32'd256);
        base  = wr_cnt;
        dbase = done_cnt;
        run(10, done_at);
        finish_run("restart", base, dbase, done_at);
        check_writes("restart", base, 32'd786432, 1'b0);

        // Reset during the 4th element's first RD_B
        load_uniform(32'd7, 32'hFFFF_FFFB);
        base = wr_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (22) @(negedge clk);
        check("abort_pre_rd", {31'd0, memread, address}, {31'd0, 1'b1, B_BASE});
        rst_n = 1'b0;
        #1;
        check("abort_strobes", {60'd0, busy, done, memread, memwrite}, 64'd0);
        check("abort_addr", {32'd0, address}, 64'd0);
        check("abort_wr_so_far", 64'(wr_cnt - base), 64'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_more_wr", 64'(wr_cnt - base), 64'd3);
        check("abort_idle", {63'd0, busy}, 64'd0);
        $display("abort: writes before reset=%0d", wr_cnt - base);

        // Fresh run after the abort
        load_identity();
        base  = wr_cnt;
        dbase = done_cnt;
        run(0, done_at);
        finish_run("post_abort", base, dbase, done_at);
        check_writes("post_abort", base, 32'd0, 1'b1);

        check("strobe_overlap", 64'(both_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
